// File: rtl/controller.sv
// controller: top-level layer sequencer of the CNN accelerator.
// Steps through LAYER_SEQ one entry per completed output feature map and
// drives layer_type to select the active datapath.
// Optional status outputs (layer_idx, done) are built when the macro
// CONTROLLER_STATUS_EN is defined.
// Reset is asynchronous and active-high on the port named rst_n.
module controller #(
  parameter logic [1:0]                CONVOLUTION = 2'b01,
  parameter logic [1:0]                POOLING     = 2'b10,
  parameter logic [1:0]                FULLY       = 2'b11,
  parameter logic [1:0]                NONE        = 2'b00,
  parameter int unsigned               NUM_LAYERS  = 7,
  parameter logic [2*NUM_LAYERS-1:0]   LAYER_SEQ   = 14'b11_11_11_10_01_10_01,
  parameter int unsigned               IDX_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ofm_valid,
  output logic [1:0]       layer_type
`ifdef CONTROLLER_STATUS_EN
  ,
  output logic [IDX_W-1:0] layer_idx,
  output logic             done
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

  logic [0:0]       state, state_d;
  logic [IDX_W-1:0] idx, idx_d, idx_nxt;
  logic [1:0]       layer_type_d;
  logic [1:0]       next_code;
  logic             ofm_valid_q;
  logic             adv;
  logic             has_next;

  // A code outside the configured layer set (NONE included) ends the sequence.
  function automatic logic is_layer(input logic [1:0] code);
    return (code != NONE) &&
           ((code == CONVOLUTION) || (code == POOLING) || (code == FULLY));
  endfunction

  assign adv     = ofm_valid & ~ofm_valid_q;
  assign idx_nxt = idx + IDX_W'(1);

  // Look up the entry that follows the current one.
  always_comb begin
    next_code = NONE;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      if (IDX_W'(i) == idx_nxt) next_code = LAYER_SEQ[2*i +: 2];
    end
  end

  assign has_next = (idx < LAST_IDX) && is_layer(next_code);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    layer_type_d = layer_type;
    case (state)
      IDLE: begin
        idx_d        = '0;
        layer_type_d = NONE;
        if (start) begin
          state_d      = RUN;
          layer_type_d = LAYER_SEQ[1:0];
        end
      end
      RUN: begin
        if (adv) begin
          if (has_next) begin
            idx_d        = idx_nxt;
            layer_type_d = next_code;
          end else begin
            state_d      = IDLE;
            idx_d        = '0;
            layer_type_d = NONE;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        idx_d        = '0;
        layer_type_d = NONE;
      end
    endcase
  end

  // State, index, edge-detect and output registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      ofm_valid_q <= 1'b0;
      layer_type  <= NONE;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      ofm_valid_q <= ofm_valid;
      layer_type  <= layer_type_d;
    end
  end

`ifdef CONTROLLER_STATUS_EN
  // Index register is already 0 in IDLE, so it is the status index directly.
  assign layer_idx = idx;

  // One-cycle pulse on the RUN to IDLE transition.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      done <= 1'b0;
    end else begin
      done <= (state == RUN) && (state_d == IDLE);
    end
  end
`endif

endmodule

// File: tb/tb_controller.sv
// Testbench for controller: a default-sequence instance and an instance whose
// third entry is NONE, both checked each cycle against a sequence-level model.
module tb_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ofm_valid;
  logic [1:0] lt0, lt1;
`ifdef CONTROLLER_STATUS_EN
  logic [2:0] idx0, idx1;
  logic       done0, done1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // model state, one slot per instance
  int seq_tab [2][7];
  bit m_run   [2];
  int m_pos   [2];
  bit m_prev  [2];
  bit m_done  [2];

  always #5 clk = ~clk;

  controller u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ofm_valid  (ofm_valid),
    .layer_type (lt0)
`ifdef CONTROLLER_STATUS_EN
    ,
    .layer_idx  (idx0),
    .done       (done0)
`endif
  );

  controller #(.LAYER_SEQ(14'b11_11_11_10_00_10_01)) u_early (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ofm_valid  (ofm_valid),
    .layer_type (lt1)
`ifdef CONTROLLER_STATUS_EN
    ,
    .layer_idx  (idx1),
    .done       (done1)
`endif
  );

  task automatic chk(input string tag, input int k, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0d expected %0d at %0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k]  = 1'b0;
      m_pos[k]  = 0;
      m_prev[k] = 1'b0;
      m_done[k] = 1'b0;
    end
  endtask

  // One clock edge of sequence-level behaviour for both instances.
  task automatic model_step(input bit s, input bit o);
    bit adv;
    for (int k = 0; k < 2; k++) begin
      adv       = o && !m_prev[k];
      m_prev[k] = o;
      m_done[k] = 1'b0;
      if (!m_run[k]) begin
        if (s) begin
          m_run[k] = 1'b1;
          m_pos[k] = 0;
        end
      end else if (adv) begin
        m_pos[k]++;
        if (m_pos[k] >= 7) begin
          m_run[k] = 1'b0; m_pos[k] = 0; m_done[k] = 1'b1;
        end else if (seq_tab[k][m_pos[k]] == 0) begin
          m_run[k] = 1'b0; m_pos[k] = 0; m_done[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("layer_type", k, int'(k == 0 ? lt0 : lt1), m_run[k] ? seq_tab[k][m_pos[k]] : 0);
`ifdef CONTROLLER_STATUS_EN
      chk("layer_idx", k, int'(k == 0 ? idx0 : idx1), m_pos[k]);
      chk("done", k, int'(k == 0 ? done0 : done1), int'(m_done[k]));
`endif
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs sampled 1 unit after the next.
  task automatic step(input bit s, input bit o);
    start     = s;
    ofm_valid = o;
    @(posedge clk);
    model_step(s, o);
    #1;
    check_all();
  endtask

  initial begin
    logic [13:0] s0, s1;
    s0 = 14'b11_11_11_10_01_10_01;
    s1 = 14'b11_11_11_10_00_10_01;
    for (int i = 0; i < 7; i++) begin
      seq_tab[0][i] = int'(s0[2*i +: 2]);
      seq_tab[1][i] = int'(s1[2*i +: 2]);
    end

    // reset held with start high: stays NONE
    rst_n     = 1'b1;
    start     = 1'b1;
    ofm_valid = 1'b0;
    model_reset();
    #3;
    check_all();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all();
    end

    // release, then a one-cycle start: first code after the edge
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // seven ofm_valid pulses walk the whole sequence back to idle
    for (int p = 0; p < 7; p++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    step(1'b0, 1'b0);

    // held ofm_valid advances exactly once
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // asynchronous reset mid-run, then restart with start held
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // randomized traffic
    repeat (400) step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
